// File: rtl/mem_bus_ctrl_if.sv
// CPU-side request/response handshake of mem_bus_ctrl.
// master = requester (CPU), slave = mem_bus_ctrl.
interface mem_bus_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_size, req_signed,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_size, req_signed,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Load/store master for the word RAM: sizing, extension, checks.
// MEM_BUS_CTRL_RMW_EN builds the sub-word store RMW path.
module mem_bus_ctrl #(
  parameter logic [31:0] ADDR_MAX = 32'd1023
) (
  input  logic        clk,
  input  logic        rst,
  mem_bus_ctrl_if.slave bus,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  inout  wire  [31:0] mem_data
);

  typedef enum logic [2:0] {
    IDLE, RD, WR, ERR, RESP
  } state_t;

  state_t      state, state_d;
  logic [1:0]  lane_q, size_q;
  logic        sgn_q;
`ifdef MEM_BUS_CTRL_RMW_EN
  logic        we_q;
  logic [15:0] wd_q;
`endif
  logic [31:0] wword_q, wword_d;
  logic        ready_d, valid_d;
  logic        err_d, we_d;
  logic [31:0] rdata_d, addr_d;
  logic        acc, bad;

  function automatic logic [31:0] ld_ext(
    input logic [31:0] w,
    input logic [1:0]  lane,
    input logic [1:0]  sz,
    input logic        sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    unique case (1'b1)
      (sz == 2'd0): r = {{24{sgn & b[7]}}, b};
      (sz == 2'd1): r = {{16{sgn & h[15]}}, h};
      default:      r = w;
    endcase
    return r;
  endfunction

`ifdef MEM_BUS_CTRL_RMW_EN
  function automatic logic [31:0] st_merge(
    input logic [31:0] w,
    input logic [15:0] wd,
    input logic [1:0]  lane,
    input logic        half
  );
    logic [31:0] r;
    r = w;
    if (half)
      r[{lane[1], 4'b0000} +: 16] = wd;
    else
      r[{lane, 3'b000} +: 8] = wd[7:0];
    return r;
  endfunction
`endif

  assign acc = bus.req_valid && bus.req_ready;

  // RAM only sees our word while we are strobing a write
  assign mem_data = mem_we ? wword_q : 'z;

  // Classify the incoming request as illegal
  always_comb begin
    bad = (bus.req_addr > ADDR_MAX)
       || (bus.req_size == 2'd3)
       || (bus.req_size == 2'd1 && bus.req_addr[0])
       || (bus.req_size == 2'd2 &&
           bus.req_addr[1:0] != 2'b00);
`ifndef MEM_BUS_CTRL_RMW_EN
    if (bus.req_we && bus.req_size != 2'd2)
      bad = 1'b1;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state and next values of all registered outputs
  always_comb begin
    state_d = state;
    rdata_d = '0;
    err_d   = 1'b0;
    addr_d  = mem_addr;
    wword_d = wword_q;
    unique case (state)
      IDLE: begin
        if (acc) begin
          addr_d = {bus.req_addr[31:2], 2'b00};
          if (bad)
            state_d = ERR;
          else if (!bus.req_we)
            state_d = RD;
          else if (bus.req_size == 2'd2) begin
            state_d = WR;
            wword_d = bus.req_wdata;
          end else
            state_d = RD;
        end
      end
      RD: begin
`ifdef MEM_BUS_CTRL_RMW_EN
        if (we_q) begin
          state_d = WR;
          wword_d = st_merge(mem_data, wd_q,
                             lane_q, size_q[0]);
        end else begin
          state_d = RESP;
          rdata_d = ld_ext(mem_data, lane_q,
                           size_q, sgn_q);
        end
`else
        state_d = RESP;
        rdata_d = ld_ext(mem_data, lane_q,
                         size_q, sgn_q);
`endif
      end
      WR:   state_d = RESP;
      ERR: begin
        state_d = RESP;
        err_d   = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == RESP);
    we_d    = (state_d == WR);
  end

  // Registered outputs and write word
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      wword_q        <= '0;
    end else begin
      bus.req_ready  <= ready_d;
      bus.resp_valid <= valid_d;
      bus.resp_rdata <= rdata_d;
      bus.resp_err   <= err_d;
      mem_we         <= we_d;
      mem_addr       <= addr_d;
      wword_q        <= wword_d;
    end
  end

  // Latch request fields on acceptance
  always_ff @(posedge clk) begin
    if (acc) begin
      lane_q <= bus.req_addr[1:0];
      size_q <= bus.req_size;
      sgn_q  <= bus.req_signed;
`ifdef MEM_BUS_CTRL_RMW_EN
      we_q   <= bus.req_we;
      wd_q   <= bus.req_wdata[15:0];
`endif
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl with a word RAM model.
// Expectations follow MEM_BUS_CTRL_RMW_EN when defined.
module tb_mem_bus_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_ctrl_if bus();
  logic        mem_we;
  logic [31:0] mem_addr;
  wire  [31:0] mem_data;

  logic [31:0] ram [0:255];

  assign mem_data = mem_we ? 32'hzzzzzzzz
                           : ram[mem_addr[9:2]];

  always @(posedge clk)
    if (mem_we) ram[mem_addr[9:2]] <= mem_data;

  mem_bus_ctrl #(.ADDR_MAX(32'd1023)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          wr_cnt  = 0;
  int          last_acc = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;
  logic        prev_we = 1'b0;
  logic        prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bus and response monitor
  always @(negedge clk) begin
    exp_t e;
    if (mem_we) begin
      wr_cnt++;
      last_wa = mem_addr;
      last_wd = mem_data;
      if (prev_we) check("we_gap", 1, 0);
    end
    prev_we = mem_we;
    if (bus.resp_valid) begin
      if (prev_valid) check("valid_pulse", 1, 0);
      if (sbq.size() == 0)
        check("spurious_resp", 1, 0);
      else begin
        e = sbq.pop_front();
        check({e.name, ".rdata"},
              bus.resp_rdata, e.rdata);
        check({e.name, ".err"},
              {31'd0, bus.resp_err}, {31'd0, e.err});
        check({e.name, ".lat"},
              cyc - e.acc, e.lat);
      end
    end
    prev_valid = bus.resp_valid;
  end

  task automatic send(input string nm,
                      input logic we,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [1:0] sz,
                      input logic sg,
                      input logic [31:0] er,
                      input logic ee,
                      input int el,
                      input bit push);
    int   n;
    exp_t e;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_size   = sz;
    bus.req_signed = sg;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready)
      check({nm, ".accept"}, 0, 1);
    else begin
      last_acc = cyc;
      if (push) begin
        e.name  = nm;
        e.rdata = er;
        e.err   = ee;
        e.lat   = el;
        e.acc   = cyc;
        sbq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    bus.req_valid = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      check("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic st_w(input string nm,
                      input logic [31:0] a,
                      input logic [31:0] d);
    send(nm, 1, a, d, 2'd2, 0, 0, 0, 2, 1);
    drain();
  endtask

  task automatic ld(input string nm,
                    input logic [31:0] a,
                    input logic [1:0] sz,
                    input logic sg,
                    input logic [31:0] er);
    send(nm, 0, a, 0, sz, sg, er, 0, 2, 1);
    drain();
  endtask

  task automatic bad(input string nm,
                     input logic we,
                     input logic [31:0] a,
                     input logic [1:0] sz);
    int w0;
    w0 = wr_cnt;
    send(nm, we, a, 32'hFFFF_FFFF, sz, 1,
         0, 1, 2, 1);
    drain();
    check({nm, ".wcnt"}, wr_cnt - w0, 0);
  endtask

  initial begin
    int w0, a1;
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, a1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_size   = '0;
    bus.req_signed = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.ready", {31'd0, bus.req_ready}, 1);
    check("rst.valid", {31'd0, bus.resp_valid}, 0);
    check("rst.rdata", bus.resp_rdata, 0);
    check("rst.err", {31'd0, bus.resp_err}, 0);
    check("rst.we", {31'd0, mem_we}, 0);
    check("rst.addr", mem_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    w0 = wr_cnt;
    st_w("st_w10", 32'h10, 32'hDEADBEEF);
    check("st_w10.wcnt", wr_cnt - w0, 1);
    check("st_w10.waddr", last_wa, 32'h10);
    check("st_w10.wdata", last_wd, 32'hDEADBEEF);
    ld("ld_w10", 32'h10, 2'd2, 0, 32'hDEADBEEF);

    st_w("st_w80", 32'h80, 32'h80FF7F01);
    ld("ld_b83s", 32'h83, 2'd0, 1, 32'hFFFFFF80);
    ld("ld_b81u", 32'h81, 2'd0, 0, 32'h0000007F);
    ld("ld_h82s", 32'h82, 2'd1, 1, 32'hFFFF80FF);
    ld("ld_h82u", 32'h82, 2'd1, 0, 32'h000080FF);
    ld("ld_b80s", 32'h80, 2'd0, 1, 32'h00000001);
    ld("ld_h80u", 32'h80, 2'd1, 0, 32'h00007F01);
    ld("ld_w80s", 32'h80, 2'd2, 1, 32'h80FF7F01);

    st_w("st_w20", 32'h20, 32'h11223344);
    w0 = wr_cnt;
`ifdef MEM_BUS_CTRL_RMW_EN
    send("st_b21", 1, 32'h21, 32'hAA, 2'd0, 0,
         0, 0, 3, 1);
    drain();
    check("st_b21.wcnt", wr_cnt - w0, 1);
    check("st_b21.waddr", last_wa, 32'h20);
    check("st_b21.wdata", last_wd, 32'h1122AA44);
    ld("ld_w20a", 32'h20, 2'd2, 0, 32'h1122AA44);
    send("st_h22", 1, 32'h22, 32'h5555BEEF, 2'd1,
         0, 0, 0, 3, 1);
    drain();
    ld("ld_w20b", 32'h20, 2'd2, 0, 32'hBEEFAA44);
`else
    bad("st_b21", 1, 32'h21, 2'd0);
    ld("ld_w20a", 32'h20, 2'd2, 0, 32'h11223344);
    bad("st_h22", 1, 32'h22, 2'd1);
    ld("ld_w20b", 32'h20, 2'd2, 0, 32'h11223344);
`endif

    bad("ld_w06", 0, 32'h06, 2'd2);
    bad("ld_w400", 0, 32'h400, 2'd2);
    bad("ld_b400", 0, 32'h400, 2'd0);
    bad("ld_sz3", 0, 32'h10, 2'd3);
    bad("st_sz3", 1, 32'h10, 2'd3);
    bad("ld_h81", 0, 32'h81, 2'd1);
    bad("st_h21", 1, 32'h21, 2'd1);
    bad("st_w400", 1, 32'h400, 2'd2);
    bad("st_w12", 1, 32'h12, 2'd2);
    ld("ld_w10b", 32'h10, 2'd2, 0, 32'hDEADBEEF);

    st_w("st_w3fc", 32'h3FC, 32'hCAFEF00D);
    ld("ld_w3fc", 32'h3FC, 2'd2, 0, 32'hCAFEF00D);
    ld("ld_b3ff", 32'h3FF, 2'd0, 0, 32'h000000CA);
    ld("ld_b3ffs", 32'h3FF, 2'd0, 1, 32'hFFFFFFCA);

    w0 = wr_cnt;
    send("b2b0", 1, 32'h0, 32'h01234567, 2'd2, 0,
         0, 0, 2, 1);
    a1 = last_acc;
    check("b2b.ready_wr", {31'd0, bus.req_ready}, 0);
    send("b2b1", 1, 32'h4, 32'h89ABCDEF, 2'd2, 0,
         0, 0, 2, 1);
    check("b2b.gap", last_acc - a1, 3);
    drain();
    check("b2b.wcnt", wr_cnt - w0, 2);
    check("b2b.wdata", last_wd, 32'h89ABCDEF);
    ld("ld_w0", 32'h0, 2'd2, 0, 32'h01234567);
    ld("ld_w4", 32'h4, 2'd2, 0, 32'h89ABCDEF);

    st_w("st_w24", 32'h24, 32'h55667788);
    w0 = wr_cnt;
    send("rst_mid", 1, 32'h24, 32'h99, 2'd0, 0,
         0, 0, 0, 0);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid.we", {31'd0, mem_we}, 0);
    check("rst_mid.ready", {31'd0, bus.req_ready}, 1);
    check("rst_mid.valid", {31'd0, bus.resp_valid}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mid.wcnt", wr_cnt - w0, 0);
    ld("ld_w24", 32'h24, 2'd2, 0, 32'h55667788);

    drain();
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
